// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN pooling stage.
// Holds the fixed-point sample type, the 25-entry window and the controller states.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int MAX_WIN   = 5;
  localparam int WIN_DEPTH = MAX_WIN * MAX_WIN;
  localparam int ADDR_W    = 16;
  localparam int DIM_W     = 8;

  typedef logic signed [DATA_W-1:0] fixed_t;
  typedef fixed_t [0:WIN_DEPTH-1] window_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPT,
    CALC,
    WRITE,
    FIN
  } state_t;

  // Low ADDR_W bits of base + row*pitch + col; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [15:0] row,
                                                 input logic [15:0] col,
                                                 input logic [15:0] pitch);
    return base + row * pitch + col;
  endfunction

endpackage

// File: rtl/pool_controller_if.sv
// Scheduler and feature-map memory signals of the pooling controller.
// The controller uses the slave view; the scheduler/memory side uses master.
interface pool_controller_if;
  import cnn_pkg::*;

  logic              start;
  logic [DIM_W-1:0]  img_size;
  logic [2:0]        win_size;
  logic [ADDR_W-1:0] in_base;
  logic [ADDR_W-1:0] out_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  fixed_t            rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  fixed_t            wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, img_size, win_size, in_base, out_base, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  start, img_size, win_size, in_base, out_base, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

endinterface

// File: rtl/pool_window.sv
// Combinational average of a packed pooling window.
// Unused entries must be zero; the sum is divided by windowSize squared, truncating toward zero.
module pool_window
  import cnn_pkg::*;
(
  input  window_t    window,
  input  logic [2:0] windowSize,
  output fixed_t     avg
);

  logic signed [DATA_W+4:0] sum;
  logic signed [DATA_W+4:0] quot;

  always_comb begin
    sum = '0;
    for (int i = 0; i < WIN_DEPTH; i++) begin
      sum = sum + (DATA_W+5)'(window[i]);
    end
  end

  always_comb begin
    quot = '0;
    case (windowSize)
      3'd2:    quot = sum / 21'sd4;
      3'd3:    quot = sum / 21'sd9;
      3'd4:    quot = sum / 21'sd16;
      3'd5:    quot = sum / 21'sd25;
      default: quot = '0;
    endcase
  end

  assign avg = DATA_W'(quot);

endmodule

// File: rtl/pool_controller.sv
// Walks non-overlapping KxK windows of an NxN map, reads each window from memory,
// averages it through pool_window and writes one output sample per window.
module pool_controller
  import cnn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pool_controller_if.slave bus
);

  state_t            state;
  logic [2:0]        k;
  logic [DIM_W-1:0]  n;
  logic [DIM_W-1:0]  m;
  logic [ADDR_W-1:0] in_b;
  logic [ADDR_W-1:0] out_b;
  logic [DIM_W-1:0]  orow;
  logic [DIM_W-1:0]  ocol;
  logic [2:0]        r;
  logic [2:0]        c;
  logic              cap_valid;
  logic [4:0]        cap_idx;
  window_t           win;
  fixed_t            avg;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  fixed_t            wr_data;
  logic              busy;
  logic              done;
  logic              err;

  logic              legal_k;
  logic [DIM_W-1:0]  m_calc;
  logic              last_elem;
  logic [2:0]        r_nx;
  logic [2:0]        c_nx;
  logic              last_win;
  logic [DIM_W-1:0]  orow_nx;
  logic [DIM_W-1:0]  ocol_nx;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] out_addr;

  pool_window u_pool_window (
    .window     (win),
    .windowSize (k),
    .avg        (avg)
  );

  assign legal_k = (bus.win_size >= 3'd2) && (bus.win_size <= 3'd5);

  always_comb begin
    m_calc = '0;
    case (bus.win_size)
      3'd2:    m_calc = bus.img_size >> 1;
      3'd3:    m_calc = bus.img_size / 8'd3;
      3'd4:    m_calc = bus.img_size >> 2;
      3'd5:    m_calc = bus.img_size / 8'd5;
      default: m_calc = '0;
    endcase
  end

  // Next element inside the window, next window in the output map, and their addresses.
  always_comb begin
    last_elem = (r == k - 3'd1) && (c == k - 3'd1);
    r_nx      = (c == k - 3'd1) ? r + 3'd1 : r;
    c_nx      = (c == k - 3'd1) ? 3'd0 : c + 3'd1;
    ocol_nx   = (ocol == m - 8'd1) ? '0 : ocol + 8'd1;
    orow_nx   = (ocol == m - 8'd1) ? orow + 8'd1 : orow;
    last_win  = (ocol == m - 8'd1) && (orow == m - 8'd1);
    load_addr = map_addr(in_b, 16'(orow) * 16'(k) + 16'(r_nx),
                         16'(ocol) * 16'(k) + 16'(c_nx), 16'(n));
    next_addr = map_addr(in_b, 16'(orow_nx) * 16'(k), 16'(ocol_nx) * 16'(k), 16'(n));
    out_addr  = map_addr(out_b, 16'(orow), 16'(ocol), 16'(m));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      n         <= '0;
      m         <= '0;
      in_b      <= '0;
      out_b     <= '0;
      orow      <= '0;
      ocol      <= '0;
      r         <= '0;
      c         <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      win       <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Read data arrives one cycle after its strobe, so the index is delayed to match.
      cap_valid <= (state == LOAD);
      cap_idx   <= 5'(r) * 5'(k) + 5'(c);
      if (cap_valid) begin
        win[cap_idx] <= bus.rd_data;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!legal_k) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else if (bus.img_size < 8'(bus.win_size)) begin
              err   <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              k       <= bus.win_size;
              n       <= bus.img_size;
              m       <= m_calc;
              in_b    <= bus.in_base;
              out_b   <= bus.out_base;
              orow    <= '0;
              ocol    <= '0;
              r       <= '0;
              c       <= '0;
              win     <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= bus.in_base;
              state   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (last_elem) begin
            rd_en <= 1'b0;
            state <= CAPT;
          end else begin
            r       <= r_nx;
            c       <= c_nx;
            rd_addr <= load_addr;
          end
        end
        CAPT: state <= CALC;
        CALC: begin
          wr_data <= avg;
          wr_en   <= 1'b1;
          wr_addr <= out_addr;
          state   <= WRITE;
        end
        WRITE: begin
          wr_en <= 1'b0;
          ocol  <= ocol_nx;
          orow  <= orow_nx;
          if (last_win) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            win     <= '0;
            r       <= '0;
            c       <= '0;
            rd_en   <= 1'b1;
            rd_addr <= next_addr;
            state   <= LOAD;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.err     = err;

endmodule

// File: doc/pool_controller.md
Name: pool_controller

Overview:
- Sequences the combinational average-pooling datapath `pool_window` over a square feature map held in an external synchronous memory.
- For each non-overlapping K×K window (stride = K), it fetches the K*K samples, packs them row-major into the 25-entry window, lets `pool_window` compute the value, and writes the result to the output map.
- Sits between the layer scheduler (start/done) and the feature-map memories, inside the CNN pooling stage.

Parameters:
- DATA_W, 16, sample width; signed fixed point, 1 sign + 4 integer + 11 fraction bits (0x0400 = 0.5).
- MAX_WIN, 5, largest supported window edge; window array depth is MAX_WIN*MAX_WIN = 25.
- ADDR_W, 16, memory address width.
- DIM_W, 8, feature-map edge width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- img_size  in  DIM_W  input map edge N; sampled at start.
- win_size  in  3  window edge K; legal range 2..5; sampled at start.
- in_base  in  ADDR_W  address of input sample (0,0); sampled at start.
- out_base  in  ADDR_W  address of output sample (0,0); sampled at start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  read data; valid exactly 1 cycle after rd_en.
- wr_en  out  1  output-memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  pooled value.
- busy  out  1  high from the cycle after an accepted start through the last WRITE cycle.
- done  out  1  one-cycle pulse on completion.
- err  out  1  high with done when K is illegal; cleared on the next accepted start.

Behaviour:
- Reset: every output is 0; FSM enters IDLE; window registers and all counters are cleared. Reset mid-operation aborts immediately with no further reads or writes. rd_data returning after reset is ignored.
- Output map: edge M = floor(N/K). Rows and columns at index M*K and above are never read.
- FSM states: IDLE, LOAD, CAPT, CALC, WRITE, FIN.
- IDLE:
  - start=1 with K in 2..5 and N>=K: latch inputs, clear all 25 window entries, go to LOAD.
  - start=1 with K illegal: go to FIN with err=1.
  - start=1 with N<K: go to FIN with err=0; no memory traffic.
- LOAD, K*K cycles:
  - Each cycle assert rd_en with rd_addr = in_base + (orow*K+r)*N + (ocol*K+c); r and c scan row-major.
  - The data returned for element index i = r*K+c is stored into window[i] one cycle later.
- CAPT, 1 cycle: no read; captures the last element. Entries K*K..24 stay 0.
- CALC, 1 cycle: register the `pool_window` output (windowSize = K) into wr_data.
- WRITE, 1 cycle:
  - wr_en=1, wr_addr = out_base + orow*M + ocol.
  - Advance ocol; when ocol wraps to 0, advance orow.
  - If more windows remain: clear the window and go to LOAD. Otherwise go to FIN.
- FIN, 1 cycle: done=1, busy=0, then IDLE.
- Latency: K*K+3 cycles per window. Total from start to done = 1 + M*M*(K*K+3) cycles; the done pulse is in the cycle after the last WRITE.
- start while busy is ignored; it is not queued.
- Address arithmetic wraps modulo 2^ADDR_W. Products are computed at full width, then truncated.
- wr_data holds its value between writes; rd_addr and wr_addr hold their last value.

Decomposition:
- Shared package `cnn_pkg`:
  - DATA_W, MAX_WIN, WIN_DEPTH=25.
  - typedef `fixed_t` (signed [15:0]).
  - typedef `window_t` (fixed_t [0:24]).
  - FSM state enum.
- Instantiate the existing `pool_window` unmodified as the single sub-module. No other sub-modules.

Test Plan:
- N=4, K=2, all samples 0x0400 → 4 writes of 0x0400 to out_base..out_base+3, each preceded by 4 reads; done at cycle 29 after start.
- N=4, K=2, sample(r,c)=0x0100*(r*4+c) → writes in order 0x0280, 0x0480, 0x0A80, 0x0C80 (exact means); first window reads addresses in_base+0, +1, +4, +5.
- N=5, K=2 → M=2, 4 writes; no rd_addr ever hits row 4 or column 4; with all 0xFC00 inputs every write is 0xFC00.
- K=6 (and separately K=1) → done and err high 1 cycle after start; no rd_en or wr_en; the next legal start clears err.
- N=6, K=3, constant 0x1400 → 4 writes of 0x1400, 9 reads per window.
- rst asserted in the 2nd LOAD cycle of window 1 → next cycle all outputs 0; start pulsed while busy is ignored; a fresh start after reset completes normally.
